// File: rtl/cmp_seq_pkg.sv
// Shared compare-result codes and state encodings used by the cmp_seq datapath block.
package cmp_seq_pkg;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_EQ = 2'b00;
  localparam cmp_code_t CMP_L  = 2'b01;
  localparam cmp_code_t CMP_G  = 2'b10;

  localparam logic [1:0] CMPS_IDLE = 2'd0;
  localparam logic [1:0] CMPS_SCAN = 2'd1;
  localparam logic [1:0] CMPS_DONE = 2'd2;

  function automatic cmp_code_t slice_result(input logic lt);
    return lt ? CMP_L : CMP_G;
  endfunction

endpackage

// File: rtl/cmp_seq_if.sv
// Operand/result handshake bundle of the sequential comparator.
interface cmp_seq_if
  import cmp_seq_pkg::*;
#(
  parameter int CPU_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CPU_WIDTH-1:0] in_a;
  logic [CPU_WIDTH-1:0] in_b;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  cmp_code_t            CMPout;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, CMPout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, CMPout, busy
  );
endinterface

// File: rtl/cmp_seq_slice.sv
// One combinational slice compare; flipping the slice MSBs turns an unsigned
// compare into a two's-complement one for the sign-carrying top slice.
module cmp_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flip_msb,
  output logic         lt,
  output logic         eq
);
  localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

  logic [W-1:0] a_f_s;
  logic [W-1:0] b_f_s;

  assign a_f_s = a ^ (flip_msb ? MSB_MASK : {W{1'b0}});
  assign b_f_s = b ^ (flip_msb ? MSB_MASK : {W{1'b0}});
  assign lt    = (a_f_s < b_f_s);
  assign eq    = (a_f_s == b_f_s);
endmodule

// File: rtl/cmp_seq.sv
// Digit-serial magnitude comparator: scans MSB-first one slice per cycle and
// stops at the first differing slice, with valid/ready on both sides.
module cmp_seq
  import cmp_seq_pkg::*;
#(
  parameter int CPU_WIDTH = 16,
  parameter int SLICE_W   = 4
) (
  input logic   clk,
  input logic   rst_n,
  cmp_seq_if.slave bus
);
  localparam int NSLICE = CPU_WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  if ((SLICE_W < 1) || (SLICE_W > CPU_WIDTH) || ((CPU_WIDTH % SLICE_W) != 0)) begin : g_bad_param
    $error("cmp_seq: CPU_WIDTH must be a multiple of SLICE_W with 1 <= SLICE_W <= CPU_WIDTH");
  end

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CPU_WIDTH-1:0] a_q, a_d;
  logic [CPU_WIDTH-1:0] b_q, b_d;
  logic                 signed_q, signed_d;
  cmp_code_t            cmp_q, cmp_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic [SLICE_W-1:0]   a_sl_s;
  logic [SLICE_W-1:0]   b_sl_s;
  logic                 flip_s;
  logic                 lt_s;
  logic                 eq_s;

  assign a_sl_s = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign b_sl_s = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign flip_s = signed_q && (idx_q == IDX_TOP);

  cmp_slice #(.W(SLICE_W)) u_slice (
    .a        (a_sl_s),
    .b        (b_sl_s),
    .flip_msb (flip_s),
    .lt       (lt_s),
    .eq       (eq_s)
  );

  // Next-state and output-register logic of the scan FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    cmp_d       = cmp_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    case (state_q)
      CMPS_IDLE: begin
        if (bus.in_valid && ready_q) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          signed_d = bus.in_signed;
          idx_d    = IDX_TOP;
          state_d  = CMPS_SCAN;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end else begin
          state_d  = CMPS_IDLE;
        end
      end
      CMPS_SCAN: begin
        if (!eq_s) begin
          cmp_d       = slice_result(lt_s);
          state_d     = CMPS_DONE;
          out_valid_d = 1'b1;
        end else if (idx_q == {IDX_W{1'b0}}) begin
          cmp_d       = CMP_EQ;
          state_d     = CMPS_DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d       = idx_q - IDX_W'(1);
        end
      end
      CMPS_DONE: begin
        if (bus.out_ready) begin
          state_d     = CMPS_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          ready_d     = 1'b1;
        end else begin
          state_d     = CMPS_DONE;
        end
      end
      default: begin
        state_d     = CMPS_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        ready_d     = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CMPS_IDLE;
      idx_q       <= IDX_TOP;
      a_q         <= {CPU_WIDTH{1'b0}};
      b_q         <= {CPU_WIDTH{1'b0}};
      signed_q    <= 1'b0;
      cmp_q       <= CMP_EQ;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      cmp_q       <= cmp_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // in_ready must read low for the whole time reset is held.
  assign bus.in_ready  = rst_n & ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.CMPout    = cmp_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cmp_seq.sv
// Directed and random checks of cmp_seq at slice widths 4, 16 and 1, run side by side.
module tb_cmp_seq;
  import cmp_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cmp_seq_if #(.CPU_WIDTH(16)) if4 ();
  cmp_seq_if #(.CPU_WIDTH(16)) if16 ();
  cmp_seq_if #(.CPU_WIDTH(16)) if1 ();

  cmp_seq #(.CPU_WIDTH(16), .SLICE_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  cmp_seq #(.CPU_WIDTH(16), .SLICE_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  cmp_seq #(.CPU_WIDTH(16), .SLICE_W(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic v);
    if4.in_a  = a; if4.in_b  = b; if4.in_signed  = s; if4.in_valid  = v;
    if16.in_a = a; if16.in_b = b; if16.in_signed = s; if16.in_valid = v;
    if1.in_a  = a; if1.in_b  = b; if1.in_signed  = s; if1.in_valid  = v;
  endtask

  task automatic set_out_ready(input logic r);
    if4.out_ready = r; if16.out_ready = r; if1.out_ready = r;
  endtask

  function automatic logic [1:0] ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic lt;
    if (a == b) return CMP_EQ;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    return lt ? CMP_L : CMP_G;
  endfunction

  // Cycles from the accept edge (counted as 1) until out_valid is first seen.
  function automatic int lat_model(input logic [15:0] a, input logic [15:0] b, input int sw);
    int n;
    logic [15:0] m;
    n = 16 / sw;
    m = 16'hFFFF >> (16 - sw);
    for (int i = n - 1; i >= 0; i--) begin
      if (((a >> (i * sw)) & m) != ((b >> (i * sw)) & m)) return (n - i) + 1;
    end
    return n + 1;
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [1:0] exp_cmp, input int exp_lat4);
    int         lat[3];
    logic [1:0] res[3];
    bit         got[3];
    int         e;
    for (int k = 0; k < 3; k++) begin lat[k] = 0; res[k] = 2'bxx; got[k] = 1'b0; end
    drive(a, b, s, 1'b1);
    set_out_ready(1'b1);
    @(posedge clk);
    #1 drive(~a, ~b, ~s, 1'b0);
    e = 1;
    while (!(got[0] && got[1] && got[2]) && (e < 40)) begin
      @(negedge clk);
      if (!got[0] && if4.out_valid)  begin got[0] = 1'b1; lat[0] = e; res[0] = if4.CMPout;  end
      if (!got[1] && if16.out_valid) begin got[1] = 1'b1; lat[1] = e; res[1] = if16.CMPout; end
      if (!got[2] && if1.out_valid)  begin got[2] = 1'b1; lat[2] = e; res[2] = if1.CMPout;  end
      if (!(got[0] && got[1] && got[2])) begin
        @(posedge clk);
        e++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "/cmp4"},  {30'd0, res[0]}, {30'd0, exp_cmp});
    check({tag, "/cmp16"}, {30'd0, res[1]}, {30'd0, exp_cmp});
    check({tag, "/cmp1"},  {30'd0, res[2]}, {30'd0, exp_cmp});
    check({tag, "/lat4"},  lat[0], (exp_lat4 > 0) ? exp_lat4 : lat_model(a, b, 4));
    check({tag, "/lat16"}, lat[1], lat_model(a, b, 16));
    check({tag, "/lat1"},  lat[2], lat_model(a, b, 1));
    check({tag, "/rdy"},   {29'd0, if4.in_ready, if16.in_ready, if1.in_ready}, 32'd7);
  endtask

  initial begin
    int e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    rst_n = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    set_out_ready(1'b0);

    // Reset state
    @(negedge clk);
    check("rst/in_ready", {31'd0, if4.in_ready}, 32'd0);
    check("rst/out_valid", {31'd0, if4.out_valid}, 32'd0);
    check("rst/cmpout", {30'd0, if4.CMPout}, {30'd0, CMP_EQ});
    check("rst/busy", {31'd0, if4.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle/in_ready", {29'd0, if4.in_ready, if16.in_ready, if1.in_ready}, 32'd7);

    // Directed vectors, S=4 latencies computed by hand
    run_op("eq1234", 16'h1234, 16'h1234, 1'b0, CMP_EQ, 5);
    run_op("u8000_7fff", 16'h8000, 16'h7FFF, 1'b0, CMP_G, 2);
    run_op("s8000_7fff", 16'h8000, 16'h7FFF, 1'b1, CMP_L, 2);
    run_op("s_m2_m1", 16'hFFFE, 16'hFFFF, 1'b1, CMP_L, 5);
    run_op("u0010_0001", 16'h0010, 16'h0001, 1'b0, CMP_G, 4);
    run_op("s0_m1", 16'h0000, 16'hFFFF, 1'b1, CMP_G, 2);
    run_op("u7fff_8000", 16'h7FFF, 16'h8000, 1'b0, CMP_L, 2);

    // Backpressure: hold out_ready low for 7 cycles once the result is up
    drive(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    set_out_ready(1'b0);
    @(posedge clk);
    #1 drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    e = 1;
    @(negedge clk);
    while (!if4.out_valid && (e < 40)) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    check("bp/lat", e, 32'd2);
    for (int i = 0; i < 7; i++) begin
      check("bp/out_valid", {31'd0, if4.out_valid}, 32'd1);
      check("bp/cmpout", {30'd0, if4.CMPout}, {30'd0, CMP_L});
      check("bp/in_ready", {31'd0, if4.in_ready}, 32'd0);
      @(negedge clk);
    end
    set_out_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    check("bp/ready_after", {31'd0, if4.in_ready}, 32'd1);
    check("bp/valid_after", {31'd0, if4.out_valid}, 32'd0);
    check("bp/busy_after", {31'd0, if4.busy}, 32'd0);
    check("bp/cmp_hold", {30'd0, if4.CMPout}, {30'd0, CMP_L});

    // Reset pulse in the middle of a scan
    drive(16'h0000, 16'h0001, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("mid/busy", {31'd0, if4.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid/out_valid", {31'd0, if4.out_valid}, 32'd0);
    check("mid/cmpout", {30'd0, if4.CMPout}, {30'd0, CMP_EQ});
    check("mid/in_ready", {31'd0, if4.in_ready}, 32'd0);
    @(negedge clk);
    check("mid/in_ready2", {29'd0, if4.in_ready, if16.in_ready, if1.in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid/no_result", {29'd0, if4.out_valid, if16.out_valid, if1.out_valid}, 32'd0);
    run_op("after_rst", 16'h0005, 16'h0003, 1'b0, CMP_G, 5);

    // Random sweep, biased toward equal and near-equal pairs
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rs, ref_cmp(ra, rb, rs), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
